// File: rtl/axi_lite_rr_arbiter.sv
// Round-robin N:1 AXI4-Lite arbiter. Only one transaction is in flight, and the granted
// master's channels are forwarded combinationally to the single downstream slave.
module axi_lite_rr_arbiter #(
   parameter  int NUM_MASTERS = 2,
   parameter  int ADDR_WIDTH  = 32,
   parameter  int DATA_WIDTH  = 32,
   localparam int STRB_WIDTH  = DATA_WIDTH / 8,
   localparam int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   // upstream write address
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_awaddr,
   input  logic [NUM_MASTERS*3-1:0]          s_awprot,
   input  logic [NUM_MASTERS-1:0]            s_awvalid,
   output logic [NUM_MASTERS-1:0]            s_awready,
   // upstream write data
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] s_wdata,
   input  logic [NUM_MASTERS*STRB_WIDTH-1:0] s_wstrb,
   input  logic [NUM_MASTERS-1:0]            s_wvalid,
   output logic [NUM_MASTERS-1:0]            s_wready,
   // upstream write response
   output logic [NUM_MASTERS*2-1:0]          s_bresp,
   output logic [NUM_MASTERS-1:0]            s_bvalid,
   input  logic [NUM_MASTERS-1:0]            s_bready,
   // upstream read address
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr,
   input  logic [NUM_MASTERS*3-1:0]          s_arprot,
   input  logic [NUM_MASTERS-1:0]            s_arvalid,
   output logic [NUM_MASTERS-1:0]            s_arready,
   // upstream read data
   output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_rdata,
   output logic [NUM_MASTERS*2-1:0]          s_rresp,
   output logic [NUM_MASTERS-1:0]            s_rvalid,
   input  logic [NUM_MASTERS-1:0]            s_rready,
   // downstream slave port
   output logic [ADDR_WIDTH-1:0]             m_awaddr,
   output logic [2:0]                        m_awprot,
   output logic                              m_awvalid,
   input  logic                              m_awready,
   output logic [DATA_WIDTH-1:0]             m_wdata,
   output logic [STRB_WIDTH-1:0]             m_wstrb,
   output logic                              m_wvalid,
   input  logic                              m_wready,
   input  logic [1:0]                        m_bresp,
   input  logic                              m_bvalid,
   output logic                              m_bready,
   output logic [ADDR_WIDTH-1:0]             m_araddr,
   output logic [2:0]                        m_arprot,
   output logic                              m_arvalid,
   input  logic                              m_arready,
   input  logic [DATA_WIDTH-1:0]             m_rdata,
   input  logic [1:0]                        m_rresp,
   input  logic                              m_rvalid,
   output logic                              m_rready,
   // status
   output logic [IDX_W-1:0]                  grant_idx,
   output logic                              busy
);

   typedef enum logic [2:0] {
      IDLE,
      WR_XFER,
      WR_RESP,
      RD_ADDR,
      RD_DATA
   } state_t;

   state_t                   r_state;
   state_t                   w_nextState;
   logic [IDX_W-1:0]         r_rrPtr;
   logic [IDX_W-1:0]         r_grantIdx;
   logic                     r_awDone;
   logic                     r_wDone;
   logic                     w_awDoneNext;
   logic                     w_wDoneNext;

   logic [NUM_MASTERS-1:0]   w_wrReq;
   logic [NUM_MASTERS-1:0]   w_req;
   logic [2*NUM_MASTERS-1:0] w_reqDbl;
   logic [2*NUM_MASTERS-1:0] w_reqShift;
   logic [NUM_MASTERS-1:0]   w_reqRot;
   logic [IDX_W-1:0]         w_offset;
   logic [IDX_W:0]           w_sum;
   logic [IDX_W-1:0]         w_pick;
   logic                     w_found;
   logic [IDX_W-1:0]         w_nextPtr;
   logic                     w_awHs;
   logic                     w_wHs;

   assign w_wrReq = s_awvalid & s_wvalid;
   assign w_req   = w_wrReq | s_arvalid;
   assign w_found = |w_req;

   // Rotate the request vector so bit 0 is the master at r_rrPtr; the lowest set bit of the
   // rotated vector is the distance from the pointer to the winner.
   assign w_reqDbl   = {w_req, w_req};
   assign w_reqShift = w_reqDbl >> r_rrPtr;
   assign w_reqRot   = w_reqShift[NUM_MASTERS-1:0];

   always_comb begin
      w_offset = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         if (w_reqRot[k]) begin
            w_offset = IDX_W'(k);
         end
      end
   end

   // Wrap pointer+offset back into 0..N-1 without relying on N being a power of two.
   always_comb begin
      w_sum = {1'b0, r_rrPtr} + {1'b0, w_offset};
      if (w_sum >= (IDX_W + 1)'(NUM_MASTERS)) begin
         w_sum = w_sum - (IDX_W + 1)'(NUM_MASTERS);
      end
      w_pick = w_sum[IDX_W-1:0];
   end

   assign w_nextPtr = (r_grantIdx == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_grantIdx + 1'b1;

   assign w_awHs = m_awvalid & m_awready;
   assign w_wHs  = m_wvalid & m_wready;

   always_comb begin
      w_nextState  = r_state;
      w_awDoneNext = r_awDone;
      w_wDoneNext  = r_wDone;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_nextState = w_wrReq[w_pick] ? WR_XFER : RD_ADDR;
            end
         end
         WR_XFER: begin
            // AW and W may complete in either order or together; leave once both have.
            if ((r_awDone || w_awHs) && (r_wDone || w_wHs)) begin
               w_nextState  = WR_RESP;
               w_awDoneNext = 1'b0;
               w_wDoneNext  = 1'b0;
            end else begin
               w_awDoneNext = r_awDone | w_awHs;
               w_wDoneNext  = r_wDone | w_wHs;
            end
         end
         WR_RESP: begin
            if (m_bvalid && m_bready) begin
               w_nextState = IDLE;
            end
         end
         RD_ADDR: begin
            if (m_arvalid && m_arready) begin
               w_nextState = RD_DATA;
            end
         end
         RD_DATA: begin
            if (m_rvalid && m_rready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state    <= IDLE;
         r_rrPtr    <= '0;
         r_grantIdx <= '0;
         r_awDone   <= 1'b0;
         r_wDone    <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_awDone <= w_awDoneNext;
         r_wDone  <= w_wDoneNext;
         if (r_state == IDLE && w_found) begin
            r_grantIdx <= w_pick;
         end
         if (r_state != IDLE && w_nextState == IDLE) begin
            r_rrPtr <= w_nextPtr;
         end
      end
   end

   // Channel forwarding: only the channel belonging to the current state is connected,
   // everything else (including IDLE and reset) is driven to zero.
   always_comb begin
      s_awready = '0;
      s_wready  = '0;
      s_bresp   = '0;
      s_bvalid  = '0;
      s_arready = '0;
      s_rdata   = '0;
      s_rresp   = '0;
      s_rvalid  = '0;
      m_awaddr  = '0;
      m_awprot  = '0;
      m_awvalid = 1'b0;
      m_wdata   = '0;
      m_wstrb   = '0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      m_araddr  = '0;
      m_arprot  = '0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      case (r_state)
         WR_XFER: begin
            m_awaddr              = s_awaddr[r_grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
            m_awprot              = s_awprot[r_grantIdx*3 +: 3];
            m_awvalid             = s_awvalid[r_grantIdx] & ~r_awDone;
            m_wdata               = s_wdata[r_grantIdx*DATA_WIDTH +: DATA_WIDTH];
            m_wstrb               = s_wstrb[r_grantIdx*STRB_WIDTH +: STRB_WIDTH];
            m_wvalid              = s_wvalid[r_grantIdx] & ~r_wDone;
            s_awready[r_grantIdx] = m_awready & ~r_awDone;
            s_wready[r_grantIdx]  = m_wready & ~r_wDone;
         end
         WR_RESP: begin
            s_bvalid[r_grantIdx]        = m_bvalid;
            s_bresp[r_grantIdx*2 +: 2]  = m_bresp;
            m_bready                    = s_bready[r_grantIdx];
         end
         RD_ADDR: begin
            m_araddr              = s_araddr[r_grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
            m_arprot              = s_arprot[r_grantIdx*3 +: 3];
            m_arvalid             = s_arvalid[r_grantIdx];
            s_arready[r_grantIdx] = m_arready;
         end
         RD_DATA: begin
            s_rvalid[r_grantIdx]                        = m_rvalid;
            s_rdata[r_grantIdx*DATA_WIDTH +: DATA_WIDTH] = m_rdata;
            s_rresp[r_grantIdx*2 +: 2]                  = m_rresp;
            m_rready                                    = s_rready[r_grantIdx];
         end
         default: begin
         end
      endcase
   end

   assign grant_idx = r_grantIdx;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Directed bench for axi_lite_rr_arbiter with three masters and a small register-bank slave
// whose AW acceptance can lag W and whose read data can be stalled.
module tb_axi_lite_rr_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic            aclk = 1'b0;
   logic            aresetn;

   logic [N*AW-1:0] s_awaddr;
   logic [N*3-1:0]  s_awprot;
   logic [N-1:0]    s_awvalid;
   logic [N-1:0]    s_awready;
   logic [N*DW-1:0] s_wdata;
   logic [N*SW-1:0] s_wstrb;
   logic [N-1:0]    s_wvalid;
   logic [N-1:0]    s_wready;
   logic [N*2-1:0]  s_bresp;
   logic [N-1:0]    s_bvalid;
   logic [N-1:0]    s_bready;
   logic [N*AW-1:0] s_araddr;
   logic [N*3-1:0]  s_arprot;
   logic [N-1:0]    s_arvalid;
   logic [N-1:0]    s_arready;
   logic [N*DW-1:0] s_rdata;
   logic [N*2-1:0]  s_rresp;
   logic [N-1:0]    s_rvalid;
   logic [N-1:0]    s_rready;

   logic [AW-1:0]   m_awaddr;
   logic [2:0]      m_awprot;
   logic            m_awvalid;
   logic            m_awready;
   logic [DW-1:0]   m_wdata;
   logic [SW-1:0]   m_wstrb;
   logic            m_wvalid;
   logic            m_wready;
   logic [1:0]      m_bresp;
   logic            m_bvalid;
   logic            m_bready;
   logic [AW-1:0]   m_araddr;
   logic [2:0]      m_arprot;
   logic            m_arvalid;
   logic            m_arready;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic            m_rvalid;
   logic            m_rready;
   logic [1:0]      grant_idx;
   logic            busy;

   int total = 0;
   int bad   = 0;

   axi_lite_rr_arbiter #(
      .NUM_MASTERS(N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .grant_idx(grant_idx), .busy(busy)
   );

   // Free-running clock, 10 time units per period.
   always #5 aclk = ~aclk;

   // Slave model: a 16-word register bank. AW acceptance can be held off until W has been
   // held for slvAwLag cycles; read data can be stalled with slvRdHold.
   logic          slvHaveAw;
   logic          slvHaveW;
   logic          slvBvalid;
   logic [AW-1:0] slvAwAddr;
   logic [DW-1:0] slvWData;
   logic          slvRPend;
   logic [AW-1:0] slvArAddr;
   logic [DW-1:0] slvMem [0:15];
   int            slvWAge;
   int            slvAwLag  = 0;
   logic [1:0]    slvBresp  = 2'd0;
   logic          slvRdHold = 1'b0;

   assign m_awready = ~slvHaveAw & ((slvAwLag == 0) | (slvHaveW & (slvWAge + 1 >= slvAwLag)));
   assign m_wready  = ~slvHaveW;
   assign m_bvalid  = slvBvalid;
   assign m_bresp   = slvBvalid ? slvBresp : 2'd0;
   assign m_arready = ~slvRPend;
   assign m_rvalid  = slvRPend & ~slvRdHold;
   assign m_rdata   = slvMem[slvArAddr[5:2]];
   assign m_rresp   = 2'd0;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         slvHaveAw <= 1'b0;
         slvHaveW  <= 1'b0;
         slvBvalid <= 1'b0;
         slvRPend  <= 1'b0;
         slvWAge   <= 0;
         slvAwAddr <= '0;
         slvArAddr <= '0;
         slvWData  <= '0;
      end else begin
         if (m_awvalid && m_awready) begin
            slvHaveAw <= 1'b1;
            slvAwAddr <= m_awaddr;
         end
         if (m_wvalid && m_wready) begin
            slvHaveW <= 1'b1;
            slvWData <= m_wdata;
         end
         if (slvHaveW && !slvHaveAw) slvWAge <= slvWAge + 1;
         if (slvHaveAw && slvHaveW && !slvBvalid) begin
            slvBvalid                <= 1'b1;
            slvMem[slvAwAddr[5:2]]   <= slvWData;
         end
         if (slvBvalid && m_bready) begin
            slvBvalid <= 1'b0;
            slvHaveAw <= 1'b0;
            slvHaveW  <= 1'b0;
            slvWAge   <= 0;
         end
         if (m_arvalid && m_arready) begin
            slvRPend  <= 1'b1;
            slvArAddr <= m_araddr;
         end
         if (m_rvalid && m_rready) slvRPend <= 1'b0;
      end
   end

   // Values captured by the stimulus tasks.
   logic [AW-1:0] lastAwAddr;
   logic [2:0]    lastAwProt;
   logic [DW-1:0] lastWData;
   logic [SW-1:0] lastWStrb;
   logic [DW-1:0] rdSeen [N];
   int            rdCyc  [N];
   int            grantLog [$];
   int            grantCyc [$];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] allHandshake();
      return {s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
   endfunction

   task automatic applyStimulus(input int m, input bit isWrite, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic [SW-1:0] strb);
      if (isWrite) begin
         s_awaddr[m*AW +: AW] = addr;
         s_awprot[m*3 +: 3]   = 3'b010;
         s_wdata[m*DW +: DW]  = data;
         s_wstrb[m*SW +: SW]  = strb;
         s_awvalid[m]         = 1'b1;
         s_wvalid[m]          = 1'b1;
      end else begin
         s_araddr[m*AW +: AW] = addr;
         s_arprot[m*3 +: 3]   = 3'b001;
         s_arvalid[m]         = 1'b1;
      end
   endtask

   task automatic applyReset();
      s_awvalid = '0;
      s_wvalid  = '0;
      s_arvalid = '0;
      aresetn   = 1'b0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   // Full write from master m; badCyc counts cycles where another master saw a ready/valid,
   // a read was forwarded, or busy dropped mid-transaction.
   task automatic doWrite(input int m, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, output logic [1:0] resp,
                          output int awCnt, output int wCnt, output int awAt, output int wAt,
                          output int badCyc, output int gIdx);
      int         budget;
      int         cyc;
      bit         started;
      bit         bDone;
      bit         hsAw, hsW, hsB;
      logic [N-1:0] om;
      budget = 200; cyc = 0; started = 0; bDone = 0;
      awCnt = 0; wCnt = 0; awAt = -1; wAt = -1; badCyc = 0; gIdx = -1; resp = 2'bxx;
      om = ~(N'(1) << m);
      applyStimulus(m, 1'b1, addr, data, strb);
      while (!bDone && budget > 0) begin
         @(negedge aclk);
         budget--;
         cyc++;
         if (busy && !started) begin
            started = 1;
            gIdx    = int'(grant_idx);
         end
         if (started && !busy) badCyc++;
         if (((s_awready | s_wready | s_bvalid | s_arready | s_rvalid) & om) != '0) badCyc++;
         if (m_arvalid) badCyc++;
         hsAw = s_awvalid[m] & s_awready[m];
         hsW  = s_wvalid[m] & s_wready[m];
         hsB  = s_bvalid[m] & s_bready[m];
         if (m_awvalid && m_awready) begin
            lastAwAddr = m_awaddr;
            lastAwProt = m_awprot;
         end
         if (m_wvalid && m_wready) begin
            lastWData = m_wdata;
            lastWStrb = m_wstrb;
         end
         if (hsB) resp = s_bresp[m*2 +: 2];
         if (hsAw) awAt = cyc;
         if (hsW) wAt = cyc;
         @(posedge aclk);
         #1;
         if (hsAw) begin s_awvalid[m] = 1'b0; awCnt++; end
         if (hsW) begin s_wvalid[m] = 1'b0; wCnt++; end
         if (hsB) bDone = 1;
      end
      checkOutput($sformatf("write m%0d completes", m), 64'(bDone), 64'd1);
   endtask

   // Runs reads already requested on s_arvalid until all are done and the arbiter is idle.
   // With keep set, masters re-request after every address handshake until maxGrants grants.
   task automatic runReads(input int maxGrants, input bit keep);
      int           budget;
      int           cyc;
      bit           prevBusy;
      logic [N-1:0] arHs;
      logic [N-1:0] rHs;
      budget = 400; cyc = 0; prevBusy = busy;
      grantLog.delete();
      grantCyc.delete();
      while (budget > 0 && (s_arvalid != '0 || busy)) begin
         @(negedge aclk);
         budget--;
         cyc++;
         if (busy && !prevBusy) begin
            grantLog.push_back(int'(grant_idx));
            grantCyc.push_back(cyc);
         end
         prevBusy = busy;
         arHs = s_arvalid & s_arready;
         rHs  = s_rvalid & s_rready;
         for (int m = 0; m < N; m++) begin
            if (rHs[m]) begin
               rdSeen[m] = s_rdata[m*DW +: DW];
               rdCyc[m]  = cyc;
            end
         end
         @(posedge aclk);
         #1;
         if (keep) begin
            if (arHs != '0 && grantLog.size() >= maxGrants) s_arvalid = '0;
         end else begin
            s_arvalid = s_arvalid & ~arHs;
         end
      end
      checkOutput("read sequence completes", 64'(s_arvalid == '0 && !busy), 64'd1);
   endtask

   initial begin
      logic [1:0] resp;
      int         awCnt, wCnt, awAt, wAt, badCyc, gIdx;
      int         budget;

      s_awaddr = '0; s_awprot = '0; s_awvalid = '0;
      s_wdata  = '0; s_wstrb  = '0; s_wvalid  = '0;
      s_araddr = '0; s_arprot = '0; s_arvalid = '0;
      s_bready = '1; s_rready = '1;
      aresetn  = 1'b0;

      // Reset state
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset grant_idx", 64'(grant_idx), 64'd0);
      checkOutput("reset handshakes", 64'(allHandshake()), 64'd0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;

      // 1: single write from s0
      doWrite(0, 32'h10, 32'hA5A5_0001, 4'hF, resp, awCnt, wCnt, awAt, wAt, badCyc, gIdx);
      checkOutput("t1 m_awaddr", 64'(lastAwAddr), 64'h10);
      checkOutput("t1 m_awprot", 64'(lastAwProt), 64'h2);
      checkOutput("t1 m_wdata", 64'(lastWData), 64'hA5A5_0001);
      checkOutput("t1 m_wstrb", 64'(lastWStrb), 64'hF);
      checkOutput("t1 bresp", 64'(resp), 64'd0);
      checkOutput("t1 grant_idx", 64'(gIdx), 64'd0);
      checkOutput("t1 aw/w count", 64'({awCnt[7:0], wCnt[7:0]}), 64'h0101);
      checkOutput("t1 isolation", 64'(badCyc), 64'd0);
      checkOutput("t1 aw/w same cycle", 64'(awAt - wAt), 64'd0);

      // Preload a word for s1 to read back
      doWrite(1, 32'h20, 32'hDEAD_BEEF, 4'hF, resp, awCnt, wCnt, awAt, wAt, badCyc, gIdx);
      checkOutput("preload grant_idx", 64'(gIdx), 64'd1);

      // 2: simultaneous reads from s0 and s1 with rr pointer at 0
      applyReset();
      @(posedge aclk);
      #1;
      applyStimulus(0, 1'b0, 32'h10, '0, '0);
      applyStimulus(1, 1'b0, 32'h20, '0, '0);
      runReads(2, 1'b0);
      checkOutput("t2 grant count", 64'(grantLog.size()), 64'd2);
      if (grantLog.size() == 2) begin
         checkOutput("t2 first grant", 64'(grantLog[0]), 64'd0);
         checkOutput("t2 second grant", 64'(grantLog[1]), 64'd1);
         checkOutput("t2 idle gap", 64'(grantCyc[1] - rdCyc[0]), 64'd2);
      end
      checkOutput("t2 s0 rdata", 64'(rdSeen[0]), 64'hA5A5_0001);
      checkOutput("t2 s1 rdata", 64'(rdSeen[1]), 64'hDEAD_BEEF);

      // 3: fairness with all three masters reading continuously
      applyReset();
      applyStimulus(0, 1'b0, 32'h10, '0, '0);
      applyStimulus(1, 1'b0, 32'h20, '0, '0);
      applyStimulus(2, 1'b0, 32'h10, '0, '0);
      runReads(9, 1'b1);
      checkOutput("t3 grant count", 64'(grantLog.size()), 64'd9);
      for (int k = 0; k < grantLog.size() && k < 9; k++) begin
         checkOutput($sformatf("t3 grant %0d", k), 64'(grantLog[k]), 64'(k % 3));
      end

      // 4: slave accepts W three cycles before AW, returns SLVERR; then same-cycle case
      slvBresp = 2'd2;
      slvAwLag = 3;
      doWrite(1, 32'h18, 32'h0BAD_0004, 4'hF, resp, awCnt, wCnt, awAt, wAt, badCyc, gIdx);
      checkOutput("t4a bresp", 64'(resp), 64'd2);
      checkOutput("t4a aw/w count", 64'({awCnt[7:0], wCnt[7:0]}), 64'h0101);
      checkOutput("t4a aw after w", 64'(awAt - wAt), 64'd3);
      checkOutput("t4a isolation", 64'(badCyc), 64'd0);
      checkOutput("t4a m_awaddr", 64'(lastAwAddr), 64'h18);
      slvAwLag = 0;
      doWrite(2, 32'h1C, 32'h0BAD_0005, 4'h3, resp, awCnt, wCnt, awAt, wAt, badCyc, gIdx);
      checkOutput("t4b bresp", 64'(resp), 64'd2);
      checkOutput("t4b aw/w count", 64'({awCnt[7:0], wCnt[7:0]}), 64'h0101);
      checkOutput("t4b aw with w", 64'(awAt - wAt), 64'd0);
      checkOutput("t4b grant_idx", 64'(gIdx), 64'd2);
      checkOutput("t4b m_wstrb", 64'(lastWStrb), 64'h3);
      slvBresp = 2'd0;

      // 5: s0 requests write and read together; write goes first, read returns its data
      applyStimulus(0, 1'b0, 32'h30, '0, '0);
      doWrite(0, 32'h30, 32'h1234_5678, 4'hF, resp, awCnt, wCnt, awAt, wAt, badCyc, gIdx);
      checkOutput("t5 write first", 64'(badCyc), 64'd0);
      checkOutput("t5 bresp", 64'(resp), 64'd0);
      runReads(1, 1'b0);
      checkOutput("t5 read grant", 64'(grantLog.size() == 1 ? grantLog[0] : -1), 64'd0);
      checkOutput("t5 readback", 64'(rdSeen[0]), 64'h1234_5678);

      // 6: reset while s2 waits in RD_DATA, then a normal write from s1
      slvRdHold = 1'b1;
      applyStimulus(2, 1'b0, 32'h10, '0, '0);
      budget = 20;
      while (budget > 0 && !(s_arvalid[2] && s_arready[2])) begin
         @(negedge aclk);
         budget--;
      end
      checkOutput("t6 address accepted", 64'(budget > 0), 64'd1);
      @(posedge aclk);
      #1;
      s_arvalid[2] = 1'b0;
      @(negedge aclk);
      checkOutput("t6 busy in read", 64'(busy), 64'd1);
      checkOutput("t6 grant_idx in read", 64'(grant_idx), 64'd2);
      checkOutput("t6 m_rready forwarded", 64'(m_rready), 64'd1);
      #2;
      aresetn = 1'b0;
      #1;
      checkOutput("t6 reset busy", 64'(busy), 64'd0);
      checkOutput("t6 reset grant_idx", 64'(grant_idx), 64'd0);
      checkOutput("t6 reset handshakes", 64'(allHandshake()), 64'd0);
      slvRdHold = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      doWrite(1, 32'h24, 32'hCAFE_0006, 4'hF, resp, awCnt, wCnt, awAt, wAt, badCyc, gIdx);
      checkOutput("t6 post-reset bresp", 64'(resp), 64'd0);
      checkOutput("t6 post-reset grant", 64'(gIdx), 64'd1);
      checkOutput("t6 post-reset m_wdata", 64'(lastWData), 64'hCAFE_0006);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
